idex_stage: RTL
===============

IDEX_STAGE -- requirements
Module: idex_stage

Interface
REQ-001 Parameter DATA_W, 16, operand/immediate width.
REQ-002 Parameter REG_W, 4, register-address width.
REQ-003 Parameter CNT_W, 16, width of each event counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 IFID_RS1, IFID_RS2, IFID_RD  input  REG_W each  decoded source and destination register addresses.
REQ-007 IFID_valid  input  1  decoded instruction present.
REQ-008 ID_rdata1, ID_rdata2, ID_imm  input  DATA_W each  register-file read data and immediate.
REQ-009 ID_regWrite, ID_memRead, ID_memWrite  input  1 each  decoded control bits.
REQ-010 ID_aluOp  input  3  ALU opcode.
REQ-011 ID_usesRS2  input  1  instruction reads RS2.
REQ-012 EX_branchTaken  input  1  branch resolved taken in EX; flush request.
REQ-013 MEM_hold  input  1  memory stage busy; freeze request.
REQ-014 IDEX_RS1, IDEX_RS2, IDEX_RD  output  REG_W each  registered addresses feeding the forwarding unit.
REQ-015 IDEX_rdata1, IDEX_rdata2, IDEX_imm  output  DATA_W each  registered operands.
REQ-016 IDEX_regWrite, IDEX_memRead, IDEX_memWrite  output  1 each  registered control bits.
REQ-017 IDEX_aluOp  output  3  registered opcode.
REQ-018 IDEX_valid  output  1  EX holds a real instruction.
REQ-019 stall_IF  output  1  combinational; holds the PC and IF/ID register.
REQ-020 flush_IFID  output  1  combinational; invalidates the IF/ID register.
REQ-021 stall_cnt, flush_cnt  output  CNT_W each  event counters.

Function
REQ-022 Load-use hazard (LU) SHALL be IDEX_valid & IDEX_memRead & IDEX_RD!=0 & IFID_valid & (IDEX_RD==IFID_RS1 | (ID_usesRS2 & IDEX_RD==IFID_RS2)).
REQ-023 Per-cycle action priority SHALL be: MEM_hold > EX_branchTaken > LU > normal.
REQ-024 HOLD: all IDEX_* registers SHALL retain their values; stall_IF=1; flush_IFID=0; a simultaneous flush or LU is ignored this cycle and re-evaluated next cycle.
REQ-025 FLUSH: the next edge SHALL load a bubble; stall_IF=0; flush_IFID=1.
REQ-026 BUBBLE definition: IDEX_valid, IDEX_regWrite, IDEX_memRead and IDEX_memWrite are 0; IDEX_aluOp=0; addresses and data are 0.
REQ-027 LU: the next edge SHALL load a bubble; stall_IF=1; flush_IFID=0; the IF/ID instruction is retained and advances on the following cycle.
REQ-028 NORMAL: the next edge SHALL capture all ID/IFID inputs; IDEX_valid<=IFID_valid; when IFID_valid=0, the control bits are forced to 0.
REQ-029 State machine states are RUN, HELD, FLUSHED and STALLED; the next state is the action taken this cycle (NORMAL->RUN, HOLD->HELD, FLUSH->FLUSHED, LU->STALLED).
REQ-030 stall_cnt SHALL increment on each edge taking the LU action.
REQ-031 flush_cnt SHALL increment on each edge taking the FLUSH action.
REQ-032 HOLD cycles SHALL count in neither counter.
REQ-033 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-034 The hazard check SHALL be purely combinational on current register state, so at most one bubble is inserted per load-use pair.
REQ-035 stall_IF and flush_IFID SHALL both be 0 while rst=1.

Reset
REQ-036 Assertion of rst SHALL immediately, without waiting for a clock edge, force all IDEX_* outputs to BUBBLE, the state to RUN, and both counters to 0.
REQ-037 Reset asserted mid-stall or mid-hold SHALL discard the pending action; after deassertion, the first edge performs a NORMAL capture if no hazard exists.

Verification
REQ-038 Load (RD=3, memRead=1) in EX with next IFID_RS1=3 -> stall_IF=1 for 1 cycle, IDEX_valid=0 next cycle, stall_cnt=1, instruction captured the cycle after.
REQ-039 Load with RD=0, IFID_RS1=0 -> no stall; stall_cnt stays 0.
REQ-040 LU condition plus EX_branchTaken=1 in the same cycle -> flush_IFID=1, stall_IF=0, bubble loaded, flush_cnt=1, stall_cnt=0.
REQ-041 MEM_hold=1 for 3 cycles with IDEX_rdata1=0x1234 -> outputs unchanged for 3 cycles; stall_IF=1; counters unchanged; the pending LU resolves after the hold.
REQ-042 stall_cnt preset near 0xFFFF by repeated LU -> stall_cnt holds 0xFFFF; it does not wrap to 0.
REQ-043 rst pulse between clock edges during STALLED -> outputs go to BUBBLE and counters to 0 immediately, before the next edge.

Source files
------------

// File: rtl/idex_stage.sv
`default_nettype none
// ============================================================================
// Module   : idex_stage
// Purpose  : ID/EX pipeline register with load-use stall, branch flush,
//            memory-hold freeze and saturating stall/flush event counters.
// Revision : 1.0  initial release
// ============================================================================
module idex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  IFID_RS1,
  input  logic [REG_W-1:0]  IFID_RS2,
  input  logic [REG_W-1:0]  IFID_RD,
  input  logic              IFID_valid,
  input  logic [DATA_W-1:0] ID_rdata1,
  input  logic [DATA_W-1:0] ID_rdata2,
  input  logic [DATA_W-1:0] ID_imm,
  input  logic              ID_regWrite,
  input  logic              ID_memRead,
  input  logic              ID_memWrite,
  input  logic [2:0]        ID_aluOp,
  input  logic              ID_usesRS2,
  input  logic              EX_branchTaken,
  input  logic              MEM_hold,
  output logic [REG_W-1:0]  IDEX_RS1,
  output logic [REG_W-1:0]  IDEX_RS2,
  output logic [REG_W-1:0]  IDEX_RD,
  output logic [DATA_W-1:0] IDEX_rdata1,
  output logic [DATA_W-1:0] IDEX_rdata2,
  output logic [DATA_W-1:0] IDEX_imm,
  output logic              IDEX_regWrite,
  output logic              IDEX_memRead,
  output logic              IDEX_memWrite,
  output logic [2:0]        IDEX_aluOp,
  output logic              IDEX_valid,
  output logic              stall_IF,
  output logic              flush_IFID,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_HELD    = 2'd1,
    S_FLUSHED = 2'd2,
    S_STALLED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t             r_state;
  logic [REG_W-1:0]   r_rs1, r_rs2, r_rd;
  logic [DATA_W-1:0]  r_rdata1, r_rdata2, r_imm;
  logic               r_reg_write, r_mem_read, r_mem_write, r_valid;
  logic [2:0]         r_alu_op;
  logic [CNT_W-1:0]   r_stall_cnt, r_flush_cnt;

  logic w_lu, w_hold, w_flush, w_stall;

  // Hazard looks only at what EX holds now, so the bubble it inserts clears it.
  assign w_lu = r_valid & r_mem_read & (r_rd != '0) & IFID_valid &
                ((r_rd == IFID_RS1) | (ID_usesRS2 & (r_rd == IFID_RS2)));

  assign w_hold  = MEM_hold;
  assign w_flush = ~MEM_hold & EX_branchTaken;
  assign w_stall = ~MEM_hold & ~EX_branchTaken & w_lu;

  assign stall_IF   = ~rst & (w_hold | w_stall);
  assign flush_IFID = ~rst & w_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rdata1    <= '0;
      r_rdata2    <= '0;
      r_imm       <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_alu_op    <= 3'd0;
      r_valid     <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (w_hold) begin
      r_state <= S_HELD;
    end else if (w_flush || w_stall) begin
      r_state     <= w_flush ? S_FLUSHED : S_STALLED;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rdata1    <= '0;
      r_rdata2    <= '0;
      r_imm       <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_alu_op    <= 3'd0;
      r_valid     <= 1'b0;
      if (w_flush && r_flush_cnt != c_cnt_max) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (w_stall && r_stall_cnt != c_cnt_max) r_stall_cnt <= r_stall_cnt + 1'b1;
    end else begin
      r_state     <= S_RUN;
      r_rs1       <= IFID_RS1;
      r_rs2       <= IFID_RS2;
      r_rd        <= IFID_RD;
      r_rdata1    <= ID_rdata1;
      r_rdata2    <= ID_rdata2;
      r_imm       <= ID_imm;
      r_alu_op    <= ID_aluOp;
      r_reg_write <= ID_regWrite & IFID_valid;
      r_mem_read  <= ID_memRead  & IFID_valid;
      r_mem_write <= ID_memWrite & IFID_valid;
      r_valid     <= IFID_valid;
    end
  end

  a_bubble_after_kill: assert property (@(posedge clk) disable iff (rst)
    ((r_state == S_FLUSHED) || (r_state == S_STALLED)) |-> !r_valid);

  assign IDEX_RS1      = r_rs1;
  assign IDEX_RS2      = r_rs2;
  assign IDEX_RD       = r_rd;
  assign IDEX_rdata1   = r_rdata1;
  assign IDEX_rdata2   = r_rdata2;
  assign IDEX_imm      = r_imm;
  assign IDEX_regWrite = r_reg_write;
  assign IDEX_memRead  = r_mem_read;
  assign IDEX_memWrite = r_mem_write;
  assign IDEX_aluOp    = r_alu_op;
  assign IDEX_valid    = r_valid;
  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;

endmodule
`default_nettype wire
